// File: rtl/pbs_disp_pkg.sv
// ---------------------------------------------------------------------------
// pbs_disp_pkg
// Shared definitions for the BCD 7-segment display block: the converter FSM
// state type and the active-low segment constants (bit order g..a).
// ---------------------------------------------------------------------------
package pbs_disp_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIBBLE_W = 4;

  // Converter FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // Active-low special patterns
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  // Digit table, SEG_DIGIT[n] is the pattern for decimal digit n
  localparam logic [9:0][SEG_W-1:0] SEG_DIGIT = {
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Pattern for one BCD nibble; non-decimal codes show as blank
  function automatic logic [SEG_W-1:0] seg_of_digit(input logic [NIBBLE_W-1:0] d);
    logic [SEG_W-1:0] v_seg;
    v_seg = SEG_BLANK;
    if (d <= 4'd9) v_seg = SEG_DIGIT[d];
    return v_seg;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// ---------------------------------------------------------------------------
// seg7_digit
// Combinational BCD nibble to active-low 7-segment decoder (bits g..a).
// Ports:
//   i_bcd    - BCD digit 0..9
//   i_blank  - 1 forces all segments off
//   o_seg_c  - active-low segment pattern
// ---------------------------------------------------------------------------
module seg7_digit
  import pbs_disp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_bcd,
  input  logic                i_blank,
  output logic [SEG_W-1:0]    o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) o_seg_c = seg_of_digit(i_bcd);
  end

endmodule

// File: rtl/bcd_seg_display.sv
// ---------------------------------------------------------------------------
// bcd_seg_display
// Converts an unsigned binary value to BCD with a serial double-dabble engine
// (one bit per cycle) and drives DIGITS active-low 7-segment digits, with
// optional leading-zero blanking, overflow dashes and blinking.
// Ports:
//   clk    - clock, all state on rising edge
//   rst    - asynchronous active-high reset
//   load   - start a conversion of value (accepted only when idle)
//   value  - unsigned binary number, WIDTH bits (WIDTH <= 64)
//   blink  - 1 flashes the display, 0 keeps it steady
//   busy   - conversion in progress
//   done   - one-cycle pulse when the display updates
//   ovf    - displayed value does not fit in DIGITS decimal digits
//   seg    - digit k on seg[7k+6:7k], digit 0 = units, active-low
// ---------------------------------------------------------------------------
module bcd_seg_display
  import pbs_disp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned BLANK_LZ  = 1,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [WIDTH-1:0]         value,
  input  logic                     blink,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic [SEG_W*DIGITS-1:0]  seg
);

  localparam int unsigned BCD_W   = NIBBLE_W * DIGITS;
  localparam int unsigned SEG_TW  = SEG_W * DIGITS;
  localparam int unsigned STEP_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Largest displayable value, 10^DIGITS - 1
  function automatic logic [63:0] f_max_val(input int unsigned d);
    logic [63:0] v_p;
    v_p = 64'd1;
    for (int unsigned i = 0; i < d; i++) v_p = v_p * 64'd10;
    return v_p - 64'd1;
  endfunction

  // Pattern shown for a zero display register
  function automatic logic [SEG_TW-1:0] f_seg_reset();
    logic [SEG_TW-1:0] v_seg;
    v_seg = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if ((k == 0) || (BLANK_LZ == 0)) v_seg[SEG_W*k +: SEG_W] = SEG_DIGIT[0];
      else                             v_seg[SEG_W*k +: SEG_W] = SEG_BLANK;
    end
    return v_seg;
  endfunction

  localparam logic [63:0]       MAX_VAL = f_max_val(DIGITS);
  localparam logic [SEG_TW-1:0] SEG_RST = f_seg_reset();

  // Converter state
  state_e              r_state,     w_state_nxt;
  logic [WIDTH-1:0]    r_shift,     w_shift_nxt;
  logic [BCD_W-1:0]    r_bcd,       w_bcd_nxt;
  logic [STEP_W-1:0]   r_step,      w_step_nxt;
  logic                r_ovf_cap,   w_ovf_cap_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;

  // Display state
  logic [BCD_W-1:0]    r_disp,      w_disp_nxt;
  logic                r_ovf,       w_ovf_nxt;
  logic [CNT_W-1:0]    r_blink_cnt, w_blink_cnt_nxt;
  logic                r_phase_off, w_phase_off_nxt;
  logic [SEG_TW-1:0]   r_seg,       w_seg_nxt;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_bcd_step;
  logic [DIGITS-1:0]   w_blank;
  logic [SEG_TW-1:0]   w_dig_seg;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_bcd[NIBBLE_W*d +: NIBBLE_W] >= 4'd5)
        w_bcd_adj[NIBBLE_W*d +: NIBBLE_W] = r_bcd[NIBBLE_W*d +: NIBBLE_W] + 4'd3;
    end
    // The top bit falls off; only overflowing values lose it and those show dashes
    w_bcd_step = BCD_W'({w_bcd_adj, r_shift[WIDTH-1]});
  end

  // FSM next-state and converter datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bcd_nxt     = r_bcd;
    w_step_nxt    = r_step;
    w_ovf_cap_nxt = r_ovf_cap;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_disp_nxt    = r_disp;
    w_ovf_nxt     = r_ovf;

    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_shift_nxt   = value;
          w_bcd_nxt     = '0;
          w_step_nxt    = '0;
          // Range is decided on the captured value, before it is shifted away
          w_ovf_cap_nxt = (64'(value) > MAX_VAL);
          w_busy_nxt    = 1'b1;
          w_state_nxt   = ST_CONV;
        end
      end
      ST_CONV: begin
        w_shift_nxt = r_shift << 1;
        w_bcd_nxt   = w_bcd_step;
        w_step_nxt  = r_step + STEP_W'(1);
        if (r_step == STEP_W'(WIDTH - 1)) begin
          w_disp_nxt  = w_bcd_step;
          w_ovf_nxt   = r_ovf_cap;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Blink phase: counter runs only while blink is high
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_off_nxt = r_phase_off;
    if (!blink) begin
      w_blink_cnt_nxt = '0;
      w_phase_off_nxt = 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      w_blink_cnt_nxt = '0;
      w_phase_off_nxt = !r_phase_off;
    end else begin
      w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
    end
  end

  // Leading-zero blanking scans from the most significant digit down
  always_comb begin
    logic v_seen;
    w_blank = '0;
    v_seen  = (BLANK_LZ == 0);
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (w_disp_nxt[NIBBLE_W*k +: NIBBLE_W] != 4'd0) v_seen = 1'b1;
      w_blank[k] = !v_seen && (k != 0);
    end
  end

  // Digit decoders work on the next display value so seg is registered
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_digit u_seg7 (
      .i_bcd   (w_disp_nxt[NIBBLE_W*k +: NIBBLE_W]),
      .i_blank (w_blank[k]),
      .o_seg_c (w_dig_seg[SEG_W*k +: SEG_W])
    );
  end

  // Blink-off overrides everything, then overflow dashes, then digits
  always_comb begin
    w_seg_nxt = w_dig_seg;
    if (w_phase_off_nxt)  w_seg_nxt = '1;
    else if (w_ovf_nxt)   w_seg_nxt = {DIGITS{SEG_DASH}};
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_step      <= '0;
      r_ovf_cap   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_disp      <= '0;
      r_ovf       <= 1'b0;
      r_blink_cnt <= '0;
      r_phase_off <= 1'b0;
      r_seg       <= SEG_RST;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bcd       <= w_bcd_nxt;
      r_step      <= w_step_nxt;
      r_ovf_cap   <= w_ovf_cap_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_disp      <= w_disp_nxt;
      r_ovf       <= w_ovf_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase_off <= w_phase_off_nxt;
      r_seg       <= w_seg_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign seg  = r_seg;

endmodule

// File: tb/tb_bcd_seg_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_display
// Directed bench for bcd_seg_display. Three instances share the stimulus:
//   a: DIGITS=3, BLANK_LZ=1    b: DIGITS=3, BLANK_LZ=0    c: DIGITS=2
// all with WIDTH=8 and BLINK_DIV=4.
// ---------------------------------------------------------------------------
module tb_bcd_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  value;
  logic        blink;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        ovf_a,  ovf_b,  ovf_c;
  logic [20:0] seg_a, seg_b;
  logic [13:0] seg_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1), .BLINK_DIV(4)) u_dut_a (
    .clk(clk), .rst(rst), .load(load), .value(value), .blink(blink),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg(seg_a)
  );

  bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0), .BLINK_DIV(4)) u_dut_b (
    .clk(clk), .rst(rst), .load(load), .value(value), .blink(blink),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg(seg_b)
  );

  bcd_seg_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1), .BLINK_DIV(4)) u_dut_c (
    .clk(clk), .rst(rst), .load(load), .value(value), .blink(blink),
    .busy(busy_c), .done(done_c), .ovf(ovf_c), .seg(seg_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Load v in cycle 0, optionally a second load in cycle l2_cyc, and watch
  // n_cyc cycles sampled on falling edges.
  task automatic run_conv(input logic [7:0] v, input int l2_cyc, input logic [7:0] l2_val,
                          input int n_cyc, output int done_cyc, output int n_done,
                          output logic busy_c1, output logic [20:0] seg_mid);
    done_cyc = -1;
    n_done   = 0;
    busy_c1  = 1'b0;
    seg_mid  = '0;
    @(negedge clk);
    value = v;
    load  = 1'b1;
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      load = (c == l2_cyc);
      if (c == l2_cyc) value = l2_val;
      if (c == 1) busy_c1 = busy_a;
      if (c == 5) seg_mid = seg_a;
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    int          dcyc;
    int          ndone;
    logic        bc1;
    logic [20:0] smid;
    logic [20:0] pat;

    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    blink = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'({busy_a, busy_b, busy_c}), 32'd0);
    check("rst_done", 32'({done_a, done_b, done_c}), 32'd0);
    check("rst_ovf",  32'({ovf_a, ovf_b, ovf_c}), 32'd0);
    check("rst_seg_a", 32'(seg_a), 32'({SB, SB, S0}));
    check("rst_seg_b", 32'(seg_b), 32'({S0, S0, S0}));
    check("rst_seg_c", 32'(seg_c), 32'({SB, S0}));

    // 200: latency, busy, seg held during conversion
    run_conv(8'd200, 0, 8'd0, 14, dcyc, ndone, bc1, smid);
    check("200_done_cyc", 32'(dcyc), 32'd9);
    check("200_done_cnt", 32'(ndone), 32'd1);
    check("200_busy_c1", 32'(bc1), 32'd1);
    check("200_seg_mid", 32'(smid), 32'({SB, SB, S0}));
    check("200_seg_a", 32'(seg_a), 32'({S2, S0, S0}));
    check("200_ovf_a", 32'(ovf_a), 32'd0);
    check("200_busy_a", 32'(busy_a), 32'd0);
    check("200_ovf_c", 32'(ovf_c), 32'd1);
    check("200_seg_c", 32'(seg_c), 32'({SD, SD}));

    // 7: leading-zero blanking on/off
    run_conv(8'd7, 0, 8'd0, 12, dcyc, ndone, bc1, smid);
    check("7_seg_a", 32'(seg_a), 32'({SB, SB, S7}));
    check("7_seg_b", 32'(seg_b), 32'({S0, S0, S7}));
    check("7_ovf_c", 32'(ovf_c), 32'd0);

    // 150 overflows two digits, 42 clears it
    run_conv(8'd150, 0, 8'd0, 12, dcyc, ndone, bc1, smid);
    check("150_ovf_c", 32'(ovf_c), 32'd1);
    check("150_seg_c", 32'(seg_c), 32'({SD, SD}));
    check("150_seg_a", 32'(seg_a), 32'({S1, S5, S0}));
    run_conv(8'd42, 0, 8'd0, 12, dcyc, ndone, bc1, smid);
    check("42_ovf_c", 32'(ovf_c), 32'd0);
    check("42_seg_c", 32'(seg_c), 32'({S4, S2}));
    check("42_seg_a", 32'(seg_a), 32'({SB, S4, S2}));

    // 99 with a load of 5 while busy: ignored
    run_conv(8'd99, 3, 8'd5, 14, dcyc, ndone, bc1, smid);
    check("99_done_cnt", 32'(ndone), 32'd1);
    check("99_done_cyc", 32'(dcyc), 32'd9);
    check("99_seg_a", 32'(seg_a), 32'({SB, S9, S9}));

    // Load on the done cycle is accepted
    run_conv(8'd123, 9, 8'd5, 25, dcyc, ndone, bc1, smid);
    check("b2b_done_cnt", 32'(ndone), 32'd2);
    check("b2b_seg_a", 32'(seg_a), 32'({SB, SB, S5}));

    // Reset in cycle 4 of a conversion of 255
    @(negedge clk);
    value = 8'd255;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_seg_a", 32'(seg_a), 32'({SB, SB, S0}));
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_seg_b", 32'(seg_b), 32'({S0, S0, S0}));
    check("abort_busy_post", 32'(busy_a), 32'd0);

    // Blink with BLINK_DIV=4
    run_conv(8'd42, 0, 8'd0, 12, dcyc, ndone, bc1, smid);
    pat = {SB, S4, S2};
    @(negedge clk);
    blink = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), 32'(seg_a),
            (((k + 1) / 4) % 2 == 1) ? 32'h1FFFFF : 32'(pat));
    end
    blink = 1'b0;
    @(negedge clk);
    check("blink_off_steady0", 32'(seg_a), 32'(pat));
    repeat (5) @(negedge clk);
    check("blink_off_steady1", 32'(seg_a), 32'(pat));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
BCD_SEG_DISPLAY -- requirements
Module: bcd_seg_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the binary input value.
REQ-002 SHALL have parameter DIGITS, default 3: number of decimal 7-segment digits driven.
REQ-003 SHALL have parameter BLANK_LZ, default 1: 1 blanks leading zeros, 0 shows them.
REQ-004 SHALL have parameter BLINK_DIV, default 25000000: clock cycles per blink half-period.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port load, input, 1 bit: request to convert and display value.
REQ-008 SHALL have port value, input, WIDTH bits: unsigned binary number to display.
REQ-009 SHALL have port blink, input, 1 bit: 1 flashes the display, 0 holds it steady.
REQ-010 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the display register updates.
REQ-012 SHALL have port ovf, output, 1 bit: the displayed value exceeds 10^DIGITS-1.
REQ-013 SHALL have port seg, output, 7*DIGITS bits, active-low: digit k on seg[7k+6:7k], digit 0 = units.

Function
REQ-014 SHALL use a two-state FSM: IDLE and CONV.
REQ-015 SHALL, in IDLE with load=1, capture value, clear the BCD accumulator, enter CONV and assert busy the next cycle.
REQ-016 SHALL, in CONV, perform one double-dabble step per cycle (add 3 to every BCD nibble >= 5, then shift left one bit), for exactly WIDTH cycles.
REQ-017 SHALL, after the last step, copy the BCD result to the display register, pulse done for one cycle, deassert busy and return to IDLE; load at cycle 0 -> done at cycle WIDTH+1.
REQ-018 SHALL ignore load while busy=1; the conversion in flight is unaffected.
REQ-019 SHALL leave seg unchanged during CONV; seg changes only on the done cycle or on a blink phase change.
REQ-020 SHALL set ovf on the done cycle when the captured value > 10^DIGITS-1, and then drive every digit as dash 0111111; it SHALL clear ovf on the next in-range done.
REQ-021 SHALL, with BLANK_LZ=1, drive every digit above the most-significant nonzero digit as blank 1111111; the units digit is always shown.
REQ-022 SHALL encode digits 0-9 (bits g..a) as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
REQ-023 SHALL run the blink counter only while blink=1, toggling the phase every BLINK_DIV cycles; in the off phase seg is all 1s; blink=0 resets the counter and forces the on phase.
REQ-024 SHALL accept a load on the cycle immediately after done.

Reset
REQ-025 SHALL, on rst=1 (asynchronous, including mid-conversion), abort any conversion, enter IDLE, and drive busy=0, done=0, ovf=0, the display register = 0, the blink counter = 0 and the phase = on.
REQ-026 SHALL drive seg at reset as units '0' (1000000), with the other digits blank if BLANK_LZ=1 or '0' if BLANK_LZ=0.

Structure
REQ-027 SHALL take the segment constants SEG_BLANK, SEG_DASH and the digit table 0-9 from shared package pbs_disp_pkg, which also holds the FSM state typedef.
REQ-028 SHALL instantiate one combinational sub-module seg7_digit (4-bit BCD in, 7-bit active-low out, blank input) once per digit.
REQ-029 SHALL keep the size of the BCD accumulator at 4*DIGITS bits; the overflow compare constant SHALL be derived from DIGITS at elaboration.

Verification
REQ-030 SHALL test WIDTH=8, DIGITS=3: load value=200 -> done at cycle 9; seg digit 2..0 = 0100100, 1000000, 1000000; ovf=0.
REQ-031 SHALL test value=7, BLANK_LZ=1 -> digits 2 and 1 = 1111111, digit 0 = 1111000; with BLANK_LZ=0, digits 2 and 1 = 1000000.
REQ-032 SHALL test DIGITS=2, value=150 -> ovf=1, both digits 0111111; then value=42 -> ovf=0, digits 0011001, 0100100.
REQ-033 SHALL test value=99 followed by load value=5 at cycle 3 (busy) -> the second load is ignored; the display shows 99 and done pulses exactly once.
REQ-034 SHALL test rst pulsed at cycle 4 of a conversion of 255 -> busy=0 immediately, no done pulse; seg shows the reset pattern.
REQ-035 SHALL test BLINK_DIV=4, blink=1 -> seg alternates between the digit patterns and all 1s every 4 cycles; blink=0 -> steady display on the next cycle.
